regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised two-read, one-write register file for the pipelined datapath.
- Adds four things:
  - synchronous clear on reset;
  - write-first bypass, so a read in the same cycle as a write to that register returns the new data;
  - an optional hardwired-zero register;
  - a per-register pending-write scoreboard, so decode can detect RAW hazards and stall.
- Sits between decode (read and issue side) and writeback (write side).

Parameters:
- WIDTH, 64: data width of each register.
- NREGS, 32: number of architectural registers (≥2).
- ZERO_EN, 1: 1 = register ZERO_REG reads as 0 and ignores writes and issues.
- ZERO_REG, 31: index of the hardwired-zero register (must be < NREGS).
- PEND_W, 2: width of each pending-write counter; max in-flight writes per register = 2^PEND_W-1.

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: synchronous, active-high.
- ra1, in, AW (AW = $clog2(NREGS)): read address, port 1.
- ra2, in, AW: read address, port 2.
- rd1, out, WIDTH: read data, port 1.
- rd2, out, WIDTH: read data, port 2.
- rbusy1, out, 1: register ra1 still has a pending write after this cycle's writeback.
- rbusy2, out, 1: same, for ra2.
- we3, in, 1: writeback enable.
- wa3, in, AW: writeback address.
- wd3, in, WIDTH: writeback data.
- issue_en, in, 1: decode issues an instruction that will write issue_rd.
- issue_rd, in, AW: destination register of the issued instruction.
- issue_ok, out, 1: issue accepted this cycle (combinational).
- sb_err, out, 1: sticky; a writeback arrived with no pending write.

Behaviour:
- Definitions:
  - zr(a) = ZERO_EN && a == ZERO_REG.
  - wb_hit(a) = we3 && wa3 == a && !zr(a).
- Reset (checked at posedge clk):
  - All REGS are cleared to 0, all counters to 0, and sb_err to 0.
  - Reset overrides every write, issue and writeback in the same cycle.
  - There is no file preload.
- Read (combinational, zero latency):
  - rdN = 0 if zr(raN).
  - Else rdN = wd3 if wb_hit(raN) (bypass).
  - Else rdN = REGS[raN].
  - Addresses ≥ NREGS read 0.
- Write: at posedge, if we3 && !zr(wa3) && wa3 < NREGS, then REGS[wa3] <= wd3.
- rbusyN (combinational):
  - rbusyN = cnt[raN] > (wb_hit(raN) ? 1 : 0).
  - rbusyN is always 0 for the zero register.
- issue_ok (combinational):
  - If zr(issue_rd): 1.
  - Otherwise: cnt[issue_rd] != MAX || wb_hit(issue_rd), where MAX = 2^PEND_W-1.
  - issue_ok is independent of issue_en.
- Counter update at posedge for register r, with inc = issue_en && issue_ok && issue_rd == r && !zr(r) and dec = wb_hit(r) && cnt[r] != 0:
  - inc & !dec: cnt+1.
  - dec & !inc: cnt-1.
  - both: unchanged (simultaneous issue and retire).
  - neither: unchanged.
- Saturation:
  - When a counter is at MAX, issue is refused (issue_ok=0) and the counter never wraps.
  - Decode must hold the instruction until issue_ok=1.
- Underflow:
  - wb_hit(r) with cnt[r]==0 still writes the data.
  - The counter stays 0.
  - sb_err is set to 1 and holds until reset.
- Zero register: never pending, and a write to it does not trigger sb_err.
- Latency:
  - A write is visible through the bypass in the same cycle and from REGS in the next cycle.
  - Counter changes are visible on rbusy and issue_ok in the next cycle.
- Reset mid-operation: all pending state is discarded. The pipeline must be flushed together with the register file.

Decomposition:
- Package regfile_pkg holds:
  - the derived AW localparam function;
  - the typedef for counter width;
  - the default ZERO_REG constant.
- Sub-module regfile_sb_ctr: one pending counter with inc, dec, sat and err outputs. It is instantiated NREGS times in a generate loop.
- Storage, bypass and port logic stay in the top module.

Test Plan:
- Reset, then read all 32 registers → all reads are 0, every rbusy=0, sb_err=0.
- we3=1, wa3=5, wd3=64'hDEADBEEF, ra1=5 in the same cycle → rd1=DEADBEEF in that cycle, and again next cycle with we3=0. With wa3=31, rd=0 forever.
- Issue rd=7 three times (PEND_W=2) → rbusy1(ra1=7)=1 and issue_ok=0 on the 4th attempt. Then on a cycle with issue_en=1, issue_rd=7 and a writeback to 7 → issue_ok=1 and the counter stays at 3.
- Counter at 1 for reg 3 plus a writeback to 3 with ra2=3 → rbusy2=0 in the same cycle, rd2=wd3, and the counter reads 0 next cycle.
- Writeback to reg 9 with no issue → data written, sb_err=1 and it stays set. Assert reset → sb_err=0 and reg 9 reads 0.
- With reset=1 together with we3=1, wa3=2, issue_en=1, issue_rd=2 → after the edge, reg 2=0, not busy, and no sb_err.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
// Address width helper, counter type and default zero-register index.
package regfile_pkg;

    localparam int DEF_ZERO_REG = 31;
    localparam int DEF_PEND_W   = 2;

    typedef logic [DEF_PEND_W-1:0] pend_t;

    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_sb_ctr.sv
// Pending-write counter for one register.
// Saturates at all-ones and never underflows.
module regfile_sb_ctr #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              wb,
    output logic [PEND_W-1:0] cnt,
    output logic              sat,
    output logic              err
);

    localparam logic [PEND_W-1:0] MAX = '1;

    logic dec;

    assign dec = wb && (cnt != '0);
    assign sat = (cnt == MAX);
    assign err = wb && (cnt == '0);

    // issue raises the count, retire lowers it, both at once cancel
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && !dec && !sat) begin
            cnt <= cnt + PEND_W'(1);
        end else if (dec && !inc) begin
            cnt <= cnt - PEND_W'(1);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-read one-write register file with write-first bypass,
// optional hardwired-zero register and pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int PEND_W   = DEF_PEND_W,
    localparam int AW      = addr_w(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             rbusy1,
    output logic             rbusy2,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_rd,
    output logic             issue_ok,
    output logic             sb_err
);

    function automatic logic zr(input logic [AW-1:0] a);
        return (ZERO_EN != 0) && (int'(a) == ZERO_REG);
    endfunction

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < NREGS;
    endfunction

    logic [WIDTH-1:0]  regs [NREGS];
    logic [PEND_W-1:0] cnt  [NREGS];
    logic [NREGS-1:0]  sat_v;
    logic [NREGS-1:0]  err_v;
    logic [NREGS-1:0]  inc_v;
    logic [NREGS-1:0]  wb_v;
    logic              hit1;
    logic              hit2;

    for (genvar r = 0; r < NREGS; r++) begin : g_ctr
        localparam bit ZR = (ZERO_EN != 0) && (r == ZERO_REG);

        assign wb_v[r]  = we3 && (wa3 == AW'(r)) && !ZR;
        assign inc_v[r] = issue_en && issue_ok &&
                          (issue_rd == AW'(r)) && !ZR;

        regfile_sb_ctr #(
            .PEND_W (PEND_W)
        ) u_ctr (
            .clk   (clk),
            .reset (reset),
            .inc   (inc_v[r]),
            .wb    (wb_v[r]),
            .cnt   (cnt[r]),
            .sat   (sat_v[r]),
            .err   (err_v[r])
        );
    end

    // architectural storage, cleared on reset, zero register never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we3 && !zr(wa3) && in_range(wa3)) begin
            regs[wa3] <= wd3;
        end
    end

    // sticky flag for a retire that had no matching issue
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_err <= 1'b0;
        end else if (|err_v) begin
            sb_err <= 1'b1;
        end
    end

    // read port 1 with bypass; busy ignores the write retiring now
    always_comb begin
        hit1   = 1'b0;
        rd1    = '0;
        rbusy1 = 1'b0;
        if (!zr(ra1) && in_range(ra1)) begin
            hit1   = we3 && (wa3 == ra1);
            rd1    = hit1 ? wd3 : regs[ra1];
            rbusy1 = (cnt[ra1] != '0) &&
                     !(hit1 && (cnt[ra1] == PEND_W'(1)));
        end
    end

    // read port 2 with bypass; busy ignores the write retiring now
    always_comb begin
        hit2   = 1'b0;
        rd2    = '0;
        rbusy2 = 1'b0;
        if (!zr(ra2) && in_range(ra2)) begin
            hit2   = we3 && (wa3 == ra2);
            rd2    = hit2 ? wd3 : regs[ra2];
            rbusy2 = (cnt[ra2] != '0) &&
                     !(hit2 && (cnt[ra2] == PEND_W'(1)));
        end
    end

    // a full counter accepts an issue only when a retire frees a slot
    always_comb begin
        issue_ok = 1'b1;
        if (!zr(issue_rd) && in_range(issue_rd)) begin
            issue_ok = !sat_v[issue_rd] ||
                       (we3 && (wa3 == issue_rd));
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed plan then random traffic,
// checked against an array-based reference model.
module tb_regfile_sb;

    localparam int W   = 64;
    localparam int N   = 32;
    localparam int ZR  = 31;
    localparam int MAX = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [4:0]   ra1 = '0;
    logic [4:0]   ra2 = '0;
    logic [W-1:0] rd1;
    logic [W-1:0] rd2;
    logic         rbusy1;
    logic         rbusy2;
    logic         we3 = 1'b0;
    logic [4:0]   wa3 = '0;
    logic [W-1:0] wd3 = '0;
    logic         issue_en = 1'b0;
    logic [4:0]   issue_rd = '0;
    logic         issue_ok;
    logic         sb_err;

    regfile_sb dut (
        .clk      (clk),
        .reset    (reset),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .rbusy1   (rbusy1),
        .rbusy2   (rbusy2),
        .we3      (we3),
        .wa3      (wa3),
        .wd3      (wd3),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .issue_ok (issue_ok),
        .sb_err   (sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] rd1;
        logic [W-1:0] rd2;
        logic         b1;
        logic         b2;
        logic         ok;
        logic         err;
    } exp_t;

    exp_t q[$];

    // reference state
    logic [W-1:0] mem [N];
    int           pend [N];
    bit           err_m;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, req);
    endtask

    function automatic bit m_zr(input int a);
        return a == ZR;
    endfunction

    function automatic bit m_hit(input int a, input bit we, input int wa);
        return we && wa == a && !m_zr(a);
    endfunction

    function automatic logic [W-1:0] m_rd(input int a, input bit we,
                                          input int wa,
                                          input logic [W-1:0] wd);
        if (m_zr(a)) return '0;
        if (m_hit(a, we, wa)) return wd;
        return mem[a];
    endfunction

    function automatic bit m_busy(input int a, input bit we, input int wa);
        if (m_zr(a)) return 1'b0;
        return pend[a] > (m_hit(a, we, wa) ? 1 : 0);
    endfunction

    function automatic bit m_ok(input int r, input bit we, input int wa);
        if (m_zr(r)) return 1'b1;
        return pend[r] < MAX || m_hit(r, we, wa);
    endfunction

    // one clock of stimulus: predict outputs, then advance the model
    task automatic step(input bit rst, input bit we, input int wa,
                        input logic [W-1:0] wd, input int a1, input int a2,
                        input bit ie, input int ird);
        exp_t e;
        bit   ok;
        @(posedge clk);
        #1;
        reset    = rst;
        we3      = we;
        wa3      = 5'(wa);
        wd3      = wd;
        ra1      = 5'(a1);
        ra2      = 5'(a2);
        issue_en = ie;
        issue_rd = 5'(ird);
        ok = m_ok(ird, we, wa);
        if (!rst) begin
            e.rd1 = m_rd(a1, we, wa, wd);
            e.rd2 = m_rd(a2, we, wa, wd);
            e.b1  = m_busy(a1, we, wa);
            e.b2  = m_busy(a2, we, wa);
            e.ok  = ok;
            e.err = err_m;
            q.push_back(e);
        end
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mem[i]  = '0;
                pend[i] = 0;
            end
            err_m = 1'b0;
        end else begin
            int d [N];
            for (int i = 0; i < N; i++) d[i] = 0;
            if (we && !m_zr(wa)) begin
                mem[wa] = wd;
                if (pend[wa] == 0) err_m = 1'b1;
                else d[wa] -= 1;
            end
            if (ie && ok && !m_zr(ird)) d[ird] += 1;
            for (int i = 0; i < N; i++) pend[i] += d[i];
        end
    endtask

    task automatic idle(input int a1, input int a2);
        step(0, 0, 0, '0, a1, a2, 0, 0);
    endtask

    // monitor: outputs are combinational, sample mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd1", rd1, e.rd1);
                chk("rd2", rd2, e.rd2);
                chk("rbusy1", W'(rbusy1), W'(e.b1));
                chk("rbusy2", W'(rbusy2), W'(e.b2));
                chk("issue_ok", W'(issue_ok), W'(e.ok));
                chk("sb_err", W'(sb_err), W'(e.err));
            end
        end
    end

    function automatic int pick_addr();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
        return int'($urandom_range(0, 5));
    endfunction

    initial begin
        for (int i = 0; i < N; i++) begin
            mem[i]  = '0;
            pend[i] = 0;
        end
        err_m = 1'b0;

        step(1, 0, 0, '0, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) idle(i, N - 1 - i);

        step(0, 0, 0, '0, 0, 0, 1, 5);
        step(0, 1, 5, 64'hDEADBEEF, 5, 31, 0, 0);
        idle(5, 5);
        step(0, 1, 31, '1, 31, 31, 0, 0);
        idle(31, 31);

        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 7, 7, 1, 7);
        step(0, 0, 0, '0, 7, 7, 1, 7);
        step(0, 1, 7, 64'h77, 7, 0, 1, 7);
        step(0, 0, 0, '0, 7, 0, 1, 7);
        for (int i = 0; i < 3; i++) step(0, 1, 7, W'(i), 7, 7, 0, 0);
        idle(7, 7);

        step(0, 0, 0, '0, 0, 3, 1, 3);
        step(0, 1, 3, 64'h1234_5678_9ABC_DEF0, 0, 3, 0, 0);
        idle(3, 3);

        step(0, 1, 9, 64'hCAFE, 9, 9, 0, 0);
        idle(9, 0);
        idle(0, 9);
        step(1, 0, 0, '0, 0, 0, 0, 0);
        idle(9, 9);

        step(0, 0, 0, '0, 0, 0, 1, 2);
        step(1, 1, 2, 64'hBAD, 2, 2, 1, 2);
        idle(2, 2);

        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
                 pick_addr(), {$urandom, $urandom}, pick_addr(),
                 pick_addr(), $urandom_range(0, 1) == 1, pick_addr());
        end

        @(posedge clk);
        @(posedge clk);
        chk("queue_drained", W'(q.size()), W'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
